// File: rtl/ram_port_arbiter_pkg.sv
// Shared state encoding, owner codes and default widths for the RAM port arbiter.
package ram_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select between CPU and DMA, with a starvation counter that forces the
// DMA through after STARVE_LIMIT consecutive CPU wins.
module ram_arb_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic idle,
    input  logic grant,
    output logic owner
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        owner = OWN_CPU;
        if (dma_req && (!cpu_req || starve_cnt == LIMIT)) begin
            owner = OWN_DMA;
        end
    end

    // Only CPU wins that leave a waiting DMA behind count toward starvation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            starve_cnt <= '0;
        end else if (grant && owner == OWN_DMA) begin
            starve_cnt <= '0;
        end else if (grant && dma_req) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (idle && !dma_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises CPU and DMA word accesses onto one single-port synchronous RAM,
// returning read data with a one-cycle done pulse to the winning requester.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RAM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              owner;
    logic              sel_owner;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [1:0]        wait_cnt;
    logic              accept;
    logic              in_idle;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && (cpu_req || dma_req);

    ram_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .Clock  (Clock),
        .Reset  (Reset),
        .cpu_req(cpu_req),
        .dma_req(dma_req),
        .idle   (in_idle),
        .grant  (accept),
        .owner  (sel_owner)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cpu_req || dma_req) next_state = ACCESS;
            ACCESS:  next_state = write_q ? DONE : WAIT;
            WAIT:    if (wait_cnt == 2'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Requests are latched once at acceptance; later input changes are ignored.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            owner       <= OWN_CPU;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= sel_owner;
                        if (sel_owner == OWN_DMA) begin
                            write_q <= dma_write;
                            addr_q  <= dma_addr;
                            wdata_q <= dma_wdata;
                        end else begin
                            write_q <= cpu_write;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                        end
                    end
                end
                ACCESS: wait_cnt <= WAIT_INIT;
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (owner == OWN_DMA) dma_rdata_q <= ram_rdata;
                        else                  cpu_rdata_q <= ram_rdata;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state == ACCESS) && write_q;
    assign cpu_done  = (state == DONE) && (owner == OWN_CPU);
    assign dma_done  = (state == DONE) && (owner == OWN_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req && !cpu_done;
    assign dma_stall = dma_req && !dma_done;
    assign busy      = (state != IDLE);

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: the CPU memory path (MAR/MDR, driven by the control unit) and the I/O DMA engine (input/output port block-transfer path).
- Serialises word accesses, selects one requester per transaction and returns read data with a one-cycle done pulse.
- Raises a stall to the control unit so ld/st/fetch states hold while the DMA owns the RAM.

Parameters:
ADDR_W, 9, RAM word-address width
DATA_W, 32, data width
RAM_LAT, 1, RAM read latency in cycles (1..4)
STARVE_LIMIT, 4, consecutive CPU grants allowed while DMA is waiting before the DMA is forced to win

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_done
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_done, held until next CPU read completes
cpu_stall  out  1  cpu_req & ~cpu_done
dma_req, dma_write, dma_addr, dma_wdata, dma_done, dma_rdata  same as cpu_*, for the DMA requester
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after the address is presented
busy  out  1  state != IDLE

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; ram_we=0 immediately; ram_addr, ram_wdata, cpu_rdata, dma_rdata=0; done pulses=0; owner=CPU; starve_cnt=0; wait_cnt=0.
- A reset mid-transaction aborts the transaction with no done pulse. Requesters re-issue.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - At the edge where any req=1, pick the owner and latch write, addr and wdata into registers. Next state is ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - CPU wins by default.
  - DMA wins if only dma_req is set, or if both are requesting and starve_cnt == STARVE_LIMIT.
  - starve_cnt increments on each CPU grant made while dma_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on a DMA grant, or in IDLE when dma_req=0.
- ACCESS:
  - ram_addr and ram_wdata come from the latched registers.
  - ram_we = latched write, for exactly one cycle.
  - Write: next state is DONE.
  - Read: wait_cnt=RAM_LAT-1, next state is WAIT.
- WAIT:
  - ram_addr is held.
  - If wait_cnt==0, capture ram_rdata into the owner's rdata register and go to DONE. Otherwise decrement wait_cnt.
- DONE: the owner's done output =1 for this cycle only. Next state is IDLE.
- Latency from the request-sampling edge to the done cycle: write = 2 cycles; read = 2+RAM_LAT cycles.
- Minimum request spacing is one IDLE cycle between transactions.
- req or addr changes after acceptance are ignored; the latched values are used.
- The non-owner's rdata register and done output are untouched.
- req deasserted mid-transaction: the transaction still completes and the done pulse is still issued.
- ram_we is never asserted outside ACCESS.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner constants (OWN_CPU=1'b0, OWN_DMA=1'b1);
  - default ADDR_W and DATA_W.
- Sub-module ram_arb_pick: the combinational winner select plus the starve_cnt register (req pair, grant strobe in, owner out).

Test Plan:
- CPU read only, RAM_LAT=1, RAM[0x010]=0xDEADBEEF: cpu_req at cycle 0 -> ram_we stays 0; cpu_done at cycle 3; cpu_rdata=0xDEADBEEF held afterwards; cpu_stall high for cycles 0-2.
- DMA write addr 0x1FF data 0x12345678 -> ram_we=1 for exactly one cycle (ACCESS) with ram_addr=0x1FF; dma_done at cycle 2; a readback then returns 0x12345678.
- Both requesting continuously with STARVE_LIMIT=4 -> grant order is CPU, CPU, CPU, CPU, DMA, CPU; starve_cnt returns to 0 after the DMA grant.
- CPU read accepted, then cpu_req dropped and cpu_addr changed next cycle -> access uses the original address; cpu_done still pulses; no second transaction starts.
- Reset asserted during WAIT of a DMA read -> ram_we=0, busy=0, dma_done never pulses, dma_rdata=0; after release, a new CPU read completes normally.
- RAM_LAT=3 read -> done exactly 5 cycles after the request-sampling edge; data captured from the ram_rdata value presented in the final WAIT cycle.
